// File: rtl/cnn_pkg.sv
// Shared types and helpers for the 3x3 conv feature-map block.
// Holds default widths, FSM states and the ReLU/saturation function.
package cnn_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_WW = 8;
  localparam int ACC_W  = DEF_DW + DEF_WW + 4;

  localparam logic signed [ACC_W-1:0] PIX_MAX =
    ACC_W'((1 << DEF_DW) - 1);

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    FLUSH  = 2'd1,
    HOLD   = 2'd2
  } conv_state_t;

  // clamp an already-shifted accumulator into the unsigned pixel range
  function automatic logic [DEF_DW-1:0] sat_relu(
    input logic signed [ACC_W-1:0] acc
  );
    if (acc[ACC_W-1])
      return '0;
    else if (acc > PIX_MAX)
      return '1;
    else
      return acc[DEF_DW-1:0];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Fixed-depth pixel delay line; advances only on enable.
// Output is the sample written DEPTH enables earlier.
module line_buffer #(
  parameter int DEPTH = 10,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  // shift one position per accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv3x3_relu_fmap.sv
// Streaming 3x3 convolution with shift, ReLU and saturation.
// Collects the full feature map and holds it until acknowledged.
module conv3x3_relu_fmap
  import cnn_pkg::*;
#(
  parameter int IMG_W = 10,
  parameter int IMG_H = 10,
  parameter int DW    = DEF_DW,
  parameter int WW    = DEF_WW,
  parameter int SHIFT = 4,
  localparam int OW   = IMG_W - 2,
  localparam int OH   = IMG_H - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wt_load,
  input  logic [3:0]           wt_idx,
  input  logic [WW-1:0]        wt_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [DW-1:0]        pix_data,
  output logic                 fmap_valid,
  input  logic                 fmap_ack,
  output logic [OH*OW*DW-1:0]  fmap_flat
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2(OH * OW);

  conv_state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          fcnt;

  logic signed [WW-1:0] w [9];
  logic [DW-1:0] win [3][3];
  logic          win_v;
  logic [AW-1:0] win_addr;

  logic signed [ACC_W-1:0] acc_c;
  logic signed [ACC_W-1:0] s1_sum;
  logic signed [ACC_W-1:0] s1_sh;
  logic                    s1_v;
  logic [AW-1:0]           s1_addr;

  logic [DW-1:0] lb1_out;
  logic [DW-1:0] lb2_out;

  logic xfer;
  logic wt_ok;
  logic last_col;
  logic last_row;

  assign xfer     = pix_valid && pix_ready;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign wt_ok    = (state == STREAM && row == '0 && col == '0)
                 || (state == HOLD);

  line_buffer #(.DEPTH(IMG_W), .W(DW)) u_lb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .din   (pix_data),
    .dout  (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W), .W(DW)) u_lb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .din   (lb1_out),
    .dout  (lb2_out)
  );

  // frame sequencing: stream pixels, drain pipeline, hold map
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STREAM;
      row        <= '0;
      col        <= '0;
      fcnt       <= 1'b0;
      pix_ready  <= 1'b1;
      fmap_valid <= 1'b0;
    end else begin
      unique case (state)
        STREAM: begin
          if (xfer) begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row       <= '0;
                state     <= FLUSH;
                fcnt      <= 1'b0;
                pix_ready <= 1'b0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (fcnt) begin
            state      <= HOLD;
            fmap_valid <= 1'b1;
          end else begin
            fcnt <= 1'b1;
          end
        end
        HOLD: begin
          if (fmap_ack) begin
            state      <= STREAM;
            row        <= '0;
            col        <= '0;
            pix_ready  <= 1'b1;
            fmap_valid <= 1'b0;
          end
        end
        default: begin
          state     <= STREAM;
          pix_ready <= 1'b1;
        end
      endcase
    end
  end

  // kernel writes only between frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++)
        w[i] <= '0;
    end else if (wt_load && wt_ok) begin
      for (int i = 0; i < 9; i++)
        if (wt_idx == 4'(i))
          w[i] <= wt_data;
    end
  end

  // 3x3 window: newest column enters on the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      win_v    <= 1'b0;
      win_addr <= '0;
    end else begin
      win_v <= xfer && (row >= RW'(2)) && (col >= CW'(2));
      if (xfer) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb2_out;
        win[1][2] <= lb1_out;
        win[2][2] <= pix_data;
        win_addr  <= AW'((int'(row) - 2) * OW + int'(col) - 2);
      end
    end
  end

  // nine unsigned-by-signed products summed
  always_comb begin
    acc_c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc_c = acc_c
          + ACC_W'(signed'({1'b0, win[i][j]}))
          * ACC_W'(w[i*3+j]);
  end

  // stage 1: register the accumulated sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum  <= '0;
      s1_v    <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_v <= win_v;
      if (win_v) begin
        s1_sum  <= acc_c;
        s1_addr <= win_addr;
      end
    end
  end

  assign s1_sh = s1_sum >>> SHIFT;

  // stage 2: scale, clamp and store into the map
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmap_flat <= '0;
    end else if (s1_v) begin
      fmap_flat[int'(s1_addr)*DW +: DW] <= sat_relu(s1_sh);
    end
  end

endmodule
